uart_rx_cfg: RTL

Parametrised UART receiver and successor to the fixed 8N1 MIDI-rate receiver. It adds configurable baud divisor, word length, bit order, parity and stop bits. It also adds an input synchroniser, glitch rejection, parity and framing error flags, and a valid/ready output handshake with overrun detection. It sits between the serial input pin and any byte consumer, such as the MIDI parser or a FIFO.

---
 rtl/uart_rx_cfg.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, mid-bit sampling, parity/framing
// checks and a valid/ready output register with overrun detection.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 722,
  parameter int DATA_BITS    = 8,
  parameter int LSB_FIRST    = 1,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_data,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD      = 1'(PARITY == 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                 state_reg;
  logic [1:0]             sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic [BW-1:0]          bit_cnt_reg;
  logic                   stop_cnt_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   perr_reg;
  logic                   ferr_reg;
  logic [DATA_BITS-1:0]   data_reg;
  logic                   valid_reg;
  logic                   perr_out_reg;
  logic                   ferr_out_reg;
  logic                   overrun_reg;
  logic                   rxd;

  assign rxd = sync_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg     <= 2'b11;
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      shift_reg    <= '0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], i_data};

      // Handshake clear; a coinciding load below overrides it.
      if (valid_reg && i_ready) begin
        valid_reg   <= 1'b0;
        overrun_reg <= 1'b0;
      end

      unique case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (!rxd) state_reg <= START;
        end
        START: begin
          if (cnt_reg == CNT_HALF) begin
            cnt_reg      <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            perr_reg     <= 1'b0;
            ferr_reg     <= 1'b0;
            state_reg    <= rxd ? IDLE : DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == CNT_FULL) begin
            cnt_reg <= '0;
            if (LSB_FIRST != 0) shift_reg <= {rxd, shift_reg[DATA_BITS-1:1]};
            else                shift_reg <= {shift_reg[DATA_BITS-2:0], rxd};
            if (bit_cnt_reg == BIT_LAST) state_reg <= (PARITY != 0) ? PAR : STOP;
            else                         bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        PAR: begin
          if (cnt_reg == CNT_FULL) begin
            cnt_reg   <= '0;
            perr_reg  <= (^shift_reg) ^ rxd ^ ODD;
            state_reg <= STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (cnt_reg == CNT_FULL) begin
            cnt_reg <= '0;
            if (STOP_BITS == 1 || stop_cnt_reg) begin
              data_reg     <= shift_reg;
              perr_out_reg <= perr_reg;
              ferr_out_reg <= ferr_reg | ~rxd;
              valid_reg    <= 1'b1;
              overrun_reg  <= valid_reg & ~i_ready;
              state_reg    <= rxd ? IDLE : WAIT_HIGH;
            end else begin
              stop_cnt_reg <= 1'b1;
              ferr_reg     <= ferr_reg | ~rxd;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_HIGH: begin
          // A held break must not retrigger START.
          if (rxd) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_data       = data_reg;
  assign o_valid      = valid_reg;
  assign o_parity_err = perr_out_reg;
  assign o_frame_err  = ferr_out_reg;
  assign o_overrun    = overrun_reg;
  assign o_busy       = (state_reg != IDLE);

endmodule
